wrr_arbiter: RTL
================

# wrr_arbiter

Weighted round-robin arbiter that shares one registered valid/ready output stream between `N` valid/ready requesters. Each requester has a runtime-programmable weight: the number of consecutive beats it may send before ownership rotates. It sits in front of a shared downstream sink such as a FIFO, bus port or scoreboard interface. It extends the two-input alternating arbiter used elsewhere in the design to N ports with bandwidth shaping.

## Interface
- `N`, 4: number of requesters, 2..16
- `WIDTH`, 32: data width
- `WBITS`, 4: weight field width per requester
- `i_clk  input  1  clock`
- `i_rst  input  1  reset; synchronous, active-low`
- `i_req_data  input  N*WIDTH  requester data; requester k occupies bits [k*WIDTH +: WIDTH]`
- `i_req_valid  input  N  per-requester valid`
- `o_req_ready  output  N  per-requester ready; at most one bit set`
- `i_weight  input  N*WBITS  per-requester weight; k at [k*WBITS +: WBITS]; a value of 0 is treated as 1`
- `o_x_data  output  WIDTH  arbitrated data`
- `o_x_valid  output  1  arbitrated valid`
- `o_x_source  output  clog2(N)  index of the requester that supplied o_x_data`
- `i_x_ready  input  1  downstream ready`

## Operation
- Output stage: one register holding data, valid and source. Define `load = !o_x_valid || i_x_ready`.
- State:
  - `owner`: clog2(N) bits, the last granted requester.
  - `cnt`: WBITS+1 bits, beats granted to `owner` in the current burst.
- Selection is combinational and is evaluated every cycle:
  - Effective weight: `w_eff(k) = max(i_weight[k], 1)`. Weights are read live; a change takes effect at the next comparison.
  - Stay: if `i_req_valid[owner]` and `cnt < w_eff(owner)`, select `owner`.
  - Rotate: otherwise, search circularly from `owner+1` through `owner+N` (inclusive, wrapping) and select the first requester with valid set.
  - The search includes `owner` itself last. A sole valid requester is therefore re-granted with a fresh burst.
  - If no requester is valid, there is no selection.
- Grant: when `load` is high and a selection exists, `o_req_ready` is set for the selected requester only.
- Handshake completes on a requester when its valid and ready are both high in the same cycle. On that edge:
  - The output register loads data, valid=1, and source = selected index.
  - If the selection was a stay, `cnt` increments.
  - If the selection was a rotate, `owner` becomes the selected index and `cnt` becomes 1.
- No transfer while `load` is high: o_x_valid clears. `owner` and `cnt` hold.
- `load` low (downstream stall): the output register, `owner` and `cnt` hold, and all `o_req_ready` bits are 0.
- An owner that drops valid mid-burst forfeits the rest of its burst. When it is next granted, it starts a fresh count.
- `cnt` never exceeds 2^WBITS − 1, so it never wraps.

## Timing
- Reset is sampled on the rising edge while `i_rst` is 0. Reset values:
  - o_x_valid=0, o_x_data=0, o_x_source=0
  - o_req_ready=0 while reset is asserted
  - owner=N−1, cnt=0
- Priority after reset: the first rotate search starts at requester 0.
- Latency: a requester handshake in cycle t produces o_x_valid=1 with that data in cycle t+1.
- Throughput: one beat per cycle while i_x_ready=1.
- o_req_ready depends combinationally on i_req_valid, i_weight and i_x_ready. It has no combinational dependence on i_req_data.
- While o_x_valid=1 and i_x_ready=0, o_x_data and o_x_source are stable.
- A requester deasserting valid while not granted is legal; this block does not enforce AXI-style valid stickiness.
- Simultaneous downstream accept and new load: both take effect in the same cycle, with no bubble.
- Reset mid-stream: the output beat is dropped and valid is 0 on the next cycle. Arbitration restarts from requester 0.

## Test plan
- Reset, then all 4 requesters valid with all weights 1, i_x_ready=1 → o_x_source sequence 0,1,2,3,0,1 with one beat per cycle; o_x_valid first high 1 cycle after the first grant.
- Weights {3,1,2,1}, all requesters valid, i_x_ready=1 → sources 0,0,0,1,2,2,3,0,0,0.
- Same traffic as above, i_x_ready held at 0 for 5 cycles mid-burst → o_x_data and o_x_source are frozen and o_req_ready=0 during the stall; after release the sequence continues exactly where it stopped.
- Weight 4 on requester 0, which sends 2 beats and then drops valid while requester 2 is valid → next source is 2. When requester 0 is later re-granted, it receives 4 consecutive beats.
- Only requester 3 valid with weight 0 → back-to-back beats every cycle from source 3; the weight is treated as 1 and `owner` stays 3.
- Assert i_rst low for 1 cycle mid-burst → next cycle o_x_valid=0 and o_x_source=0; with all requesters valid, the first new grant goes to requester 0.

Source files
------------

// File: rtl/wrr_arbiter_if.sv
// Bundle of N requester streams and the single arbitrated output stream for wrr_arbiter.
// Handshake: a beat moves on a rising edge where valid and ready are both high; data is held stable while valid waits.
interface wrr_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    parameter int WBITS = 4
);
    localparam int SW = $clog2(N);

    logic [N*WIDTH-1:0] i_req_data;
    logic [N-1:0]       i_req_valid;
    logic [N-1:0]       o_req_ready;
    logic [N*WBITS-1:0] i_weight;
    logic [WIDTH-1:0]   o_x_data;
    logic               o_x_valid;
    logic [SW-1:0]      o_x_source;
    logic               i_x_ready;

    modport slave (
        input  i_req_data, i_req_valid, i_weight, i_x_ready,
        output o_req_ready, o_x_data, o_x_valid, o_x_source
    );

    modport master (
        output i_req_data, i_req_valid, i_weight, i_x_ready,
        input  o_req_ready, o_x_data, o_x_valid, o_x_source
    );
endinterface

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: N requesters share one registered output stream,
// each owning the output for up to its programmed weight of consecutive beats.
module wrr_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    parameter int WBITS = 4,
    localparam int SW   = $clog2(N)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    wrr_arbiter_if.slave       bus,
    output logic [SW-1:0]      o_dbg_owner,
    output logic [WBITS:0]     o_dbg_cnt
);
    logic [WIDTH-1:0] x_data_q, x_data_d;
    logic             x_valid_q, x_valid_d;
    logic [SW-1:0]    x_source_q, x_source_d;
    logic [SW-1:0]    owner_q, owner_d;
    logic [WBITS:0]   cnt_q, cnt_d;

    logic             load;
    logic [WBITS-1:0] owner_w;
    logic [WBITS:0]   w_eff;
    logic             stay;
    logic             found;
    logic [SW-1:0]    rot_sel;
    logic [SW-1:0]    sel;
    logic             grant;
    logic [N-1:0]     ready;

    always_comb begin
        load    = !x_valid_q || bus.i_x_ready;
        owner_w = bus.i_weight[int'(owner_q)*WBITS +: WBITS];
        w_eff   = (owner_w == '0) ? (WBITS+1)'(1) : {1'b0, owner_w};
        // cnt of zero means no burst is live (reset state), so it never counts as a stay
        stay    = bus.i_req_valid[owner_q] && (cnt_q != '0) && (cnt_q < w_eff);

        // Walk farthest-to-nearest so the nearest valid requester after owner wins; owner itself is last
        found   = 1'b0;
        rot_sel = '0;
        for (int i = N; i >= 1; i--) begin
            if (bus.i_req_valid[(int'(owner_q) + i) % N]) begin
                rot_sel = SW'((int'(owner_q) + i) % N);
                found   = 1'b1;
            end
        end

        sel   = stay ? owner_q : rot_sel;
        grant = i_rst && load && (stay || found);
        ready = '0;
        if (grant) ready[sel] = 1'b1;

        x_data_d   = x_data_q;
        x_valid_d  = x_valid_q;
        x_source_d = x_source_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        if (load) begin
            x_valid_d = grant;
            if (grant) begin
                x_data_d   = bus.i_req_data[int'(sel)*WIDTH +: WIDTH];
                x_source_d = sel;
                if (stay) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    owner_d = sel;
                    cnt_d   = (WBITS+1)'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            x_data_q   <= '0;
            x_valid_q  <= 1'b0;
            x_source_q <= '0;
            owner_q    <= SW'(N-1);
            cnt_q      <= '0;
        end else begin
            x_data_q   <= x_data_d;
            x_valid_q  <= x_valid_d;
            x_source_q <= x_source_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.o_req_ready = ready;
    assign bus.o_x_data    = x_data_q;
    assign bus.o_x_valid   = x_valid_q;
    assign bus.o_x_source  = x_source_q;
    assign o_dbg_owner     = owner_q;
    assign o_dbg_cnt       = cnt_q;
endmodule
